// File: rtl/cla_accum.sv
// cla_accum: two-stage pipelined two's-complement accumulator.
// Stage 1 registers the operand. Stage 2 adds or subtracts it into the
// accumulator through a grouped carry-lookahead adder, with optional
// saturation, a sticky signed-overflow flag and a saturating sample counter.
module cla_accum #(
  parameter int WIDTH    = 17,
  parameter int GROUP    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sub,
  input  logic             clear,
  output logic [WIDTH-1:0] acc_q,
  output logic             out_valid,
  output logic             ovf,
  output logic [7:0]       count
);

  // Number of CLA groups; the top group is narrower when WIDTH % GROUP != 0.
  localparam int NGRP = (WIDTH + GROUP - 1) / GROUP;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage 1 state
  logic [WIDTH-1:0] op_q;
  logic             sub_q;
  logic             op_valid_q;

  // Stage 2 state (acc_q is itself the accumulator register)
  logic [WIDTH-1:0] acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;

  // Adder internals
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] bit_g, bit_p;
  logic [NGRP-1:0]  grp_g, grp_p;
  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] sum;
  logic             la_carry, la_prop;
  logic             ovf_now;

  // Stage 1 valid: clear and reset both flush a pending operand.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      op_valid_q <= 1'b0;
    end else begin
      op_valid_q <= in_valid;
    end
  end

  // Stage 1 payload: only loaded with a valid sample.
  // NOTE: payload registers carry no reset; op_valid_q gates every use of them.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      op_q  <= in_data;
      sub_q <= sub;
    end
  end

  // Grouped carry-lookahead adder computing acc_q + (sub ? ~op : op) + sub.
  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    b_eff    = sub_q ? ~op_q : op_q;
    bit_g    = acc_q & b_eff;
    bit_p    = acc_q | b_eff;
    grp_g    = '0;
    grp_p    = '0;
    grp_c    = '0;
    bit_c    = '0;
    la_carry = 1'b0;
    la_prop  = 1'b1;

    // Group generate/propagate, built from the group's LSB upward.
    // NOTE: blocking assignments here, so later lines see the updated values.
    for (int i = 0; i < WIDTH; i++) begin
      if (i % GROUP == 0) begin
        grp_g[i / GROUP] = bit_g[i];
        grp_p[i / GROUP] = bit_p[i];
      end else begin
        grp_g[i / GROUP] = bit_g[i] | (bit_p[i] & grp_g[i / GROUP]);
        grp_p[i / GROUP] = bit_p[i] & grp_p[i / GROUP];
      end
    end

    // Carry into each group in flat sum-of-products form, so no group waits
    // on the carry of the group below it. grp_c[NGRP] is the MSB carry-out.
    grp_c[0] = sub_q;
    for (int k = 0; k < NGRP; k++) begin
      la_carry = 1'b0;
      la_prop  = 1'b1;
      for (int j = k; j >= 0; j--) begin
        la_carry = la_carry | (la_prop & grp_g[j]);
        la_prop  = la_prop & grp_p[j];
      end
      grp_c[k + 1] = la_carry | (la_prop & sub_q);
    end

    // Bit carries inside each group start from the lookahead group carry.
    bit_c[0] = grp_c[0];
    for (int i = 1; i < WIDTH; i++) begin
      if (i % GROUP == 0) begin
        bit_c[i] = grp_c[i / GROUP];
      end else begin
        bit_c[i] = bit_g[i-1] | (bit_p[i-1] & bit_c[i-1]);
      end
    end

    sum     = acc_q ^ b_eff ^ bit_c;
    ovf_now = bit_c[WIDTH-1] ^ grp_c[NGRP];
  end

  // Stage 2 next state: accumulate, saturate if enabled, update flags.
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    if (op_valid_q) begin
      out_valid_d = 1'b1;
      ovf_d       = ovf_q | ovf_now;
      count_d     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      if ((SATURATE != 0) && ovf_now) begin
        // On overflow both effective operands share acc_q's sign bit.
        acc_d = acc_q[WIDTH-1] ? MAX_NEG : MAX_POS;
      end else begin
        acc_d = sum;
      end
    end
  end

  // Stage 2 registers; reset and clear return the same state.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_cla_accum.sv
// tb_cla_accum: scoreboard bench for cla_accum. Three instances: 17/4 wrap,
// 17/4 saturate, 10/3 wrap (narrow top group). Expected results are queued
// when a sample is issued and popped by a monitor on each out_valid.
module tb_cla_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 17-bit wrapping instance
  logic        w_in_valid, w_sub, w_clear;
  logic [16:0] w_in_data, w_acc;
  logic        w_out_valid, w_ovf;
  logic [7:0]  w_count;

  // 17-bit saturating instance
  logic        s_in_valid, s_sub, s_clear;
  logic [16:0] s_in_data, s_acc;
  logic        s_out_valid, s_ovf;
  logic [7:0]  s_count;

  // 10-bit wrapping instance with GROUP=3
  logic        n_in_valid, n_sub, n_clear;
  logic [9:0]  n_in_data, n_acc;
  logic        n_out_valid, n_ovf;
  logic [7:0]  n_count;

  cla_accum #(.WIDTH(17), .GROUP(4), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_data(w_in_data),
    .sub(w_sub), .clear(w_clear), .acc_q(w_acc), .out_valid(w_out_valid),
    .ovf(w_ovf), .count(w_count)
  );

  cla_accum #(.WIDTH(17), .GROUP(4), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data),
    .sub(s_sub), .clear(s_clear), .acc_q(s_acc), .out_valid(s_out_valid),
    .ovf(s_ovf), .count(s_count)
  );

  cla_accum #(.WIDTH(10), .GROUP(3), .SATURATE(0)) u_narrow (
    .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_data(n_in_data),
    .sub(n_sub), .clear(n_clear), .acc_q(n_acc), .out_valid(n_out_valid),
    .ovf(n_ovf), .count(n_count)
  );

  typedef struct packed {
    logic [16:0] acc;
    logic        ovf;
    logic [7:0]  cnt;
  } exp17_t;

  typedef struct packed {
    logic [9:0] acc;
    logic       ovf;
    logic [7:0] cnt;
  } exp10_t;

  exp17_t w_q[$];
  exp17_t s_q[$];
  exp10_t n_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: one pop per out_valid; an output with nothing queued is an error.
  always @(negedge clk) begin
    exp17_t e17;
    exp10_t e10;
    if (w_out_valid === 1'b1) begin
      if (w_q.size() == 0) check("w_unexpected_out_valid", 32'd1, 32'd0);
      else begin
        e17 = w_q.pop_front();
        check("w_acc", 32'(w_acc), 32'(e17.acc));
        check("w_ovf", 32'(w_ovf), 32'(e17.ovf));
        check("w_count", 32'(w_count), 32'(e17.cnt));
      end
    end
    if (s_out_valid === 1'b1) begin
      if (s_q.size() == 0) check("s_unexpected_out_valid", 32'd1, 32'd0);
      else begin
        e17 = s_q.pop_front();
        check("s_acc", 32'(s_acc), 32'(e17.acc));
        check("s_ovf", 32'(s_ovf), 32'(e17.ovf));
        check("s_count", 32'(s_count), 32'(e17.cnt));
      end
    end
    if (n_out_valid === 1'b1) begin
      if (n_q.size() == 0) check("n_unexpected_out_valid", 32'd1, 32'd0);
      else begin
        e10 = n_q.pop_front();
        check("n_acc", 32'(n_acc), 32'(e10.acc));
        check("n_ovf", 32'(n_ovf), 32'(e10.ovf));
        check("n_count", 32'(n_count), 32'(e10.cnt));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic w_send(input int d, input int s, input int ea, input int eo, input int ec);
    exp17_t e;
    e.acc = 17'(ea); e.ovf = 1'(eo); e.cnt = 8'(ec);
    w_q.push_back(e);
    w_in_valid = 1'b1; w_in_data = 17'(d); w_sub = 1'(s);
    tick(1);
    w_in_valid = 1'b0;
  endtask

  task automatic s_send(input int d, input int s, input int ea, input int eo, input int ec);
    exp17_t e;
    e.acc = 17'(ea); e.ovf = 1'(eo); e.cnt = 8'(ec);
    s_q.push_back(e);
    s_in_valid = 1'b1; s_in_data = 17'(d); s_sub = 1'(s);
    tick(1);
    s_in_valid = 1'b0;
  endtask

  task automatic w_clear_pulse();
    w_clear = 1'b1;
    tick(1);
    w_clear = 1'b0;
  endtask

  task automatic s_clear_pulse();
    s_clear = 1'b1;
    tick(1);
    s_clear = 1'b0;
  endtask

  task automatic check_w_idle(input string tag);
    @(negedge clk);
    check({tag, "_acc"}, 32'(w_acc), 32'd0);
    check({tag, "_ovf"}, 32'(w_ovf), 32'd0);
    check({tag, "_count"}, 32'(w_count), 32'd0);
    tick(1);
  endtask

  // Narrow-instance reference model state
  int   m_acc;
  logic m_ovf;
  int   m_cnt;

  initial begin
    reset = 1'b1;
    w_clear = 1'b0; s_clear = 1'b0; n_clear = 1'b0;
    w_in_valid = 1'b1; w_in_data = 17'd5; w_sub = 1'b0;
    s_in_valid = 1'b1; s_in_data = 17'd5; s_sub = 1'b0;
    n_in_valid = 1'b1; n_in_data = 10'd5; n_sub = 1'b0;

    // Reset held for two edges with a valid sample present.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_w_acc", 32'(w_acc), 32'd0);
      check("rst_w_ovf", 32'(w_ovf), 32'd0);
      check("rst_w_count", 32'(w_count), 32'd0);
      check("rst_w_out_valid", 32'(w_out_valid), 32'd0);
      check("rst_s_acc", 32'(s_acc), 32'd0);
      check("rst_n_acc", 32'(n_acc), 32'd0);
    end
    reset = 1'b0;
    w_in_valid = 1'b0; s_in_valid = 1'b0; n_in_valid = 1'b0;
    tick(2);
    check_w_idle("post_rst_w");
    check("post_rst_w_out_valid", 32'(w_out_valid), 32'd0);

    // Streaming, back to back.
    w_send(100, 0, 100, 0, 1);
    w_send(200, 0, 300, 0, 2);
    w_send(-50, 0, 250, 0, 3);
    tick(3);
    w_clear_pulse();
    check_w_idle("clr1_w");

    // Wrap overflow and sticky flag.
    w_send(65000, 0, 65000, 0, 1);
    w_send(1000, 0, -65072, 1, 2);
    w_send(100, 0, -64972, 1, 3);
    tick(3);

    // Sample captured in stage 1, clear on the following cycle.
    w_in_valid = 1'b1; w_in_data = 17'd7; w_sub = 1'b0;
    tick(1);
    w_in_valid = 1'b0; w_clear = 1'b1;
    tick(1);
    w_clear = 1'b0;
    tick(3);
    check_w_idle("flush_w");

    // Clear and a valid sample in the same cycle.
    w_send(11, 0, 11, 0, 1);
    tick(2);
    w_clear = 1'b1; w_in_valid = 1'b1; w_in_data = 17'd9;
    tick(1);
    w_clear = 1'b0; w_in_valid = 1'b0;
    tick(3);
    check_w_idle("drop_w");

    // Subtracting the most-negative value wraps; ordinary subtraction.
    w_send(-65536, 1, -65536, 1, 1);
    w_send(40, 1, 65496, 1, 2);
    tick(3);
    w_clear_pulse();
    w_send(300, 1, -300, 0, 1);
    w_send(-500, 0, -800, 0, 2);
    w_send(-1000, 1, 200, 0, 3);
    tick(3);

    // Saturating instance: positive clamp.
    s_send(65000, 0, 65000, 0, 1);
    s_send(1000, 0, 65535, 1, 2);
    s_send(5, 0, 65535, 1, 3);
    tick(3);
    s_clear_pulse();
    // Negative clamp holds at the most-negative value.
    s_send(65535, 1, -65535, 0, 1);
    s_send(1, 1, -65536, 0, 2);
    s_send(1, 1, -65536, 1, 3);
    s_send(1, 1, -65536, 1, 4);
    tick(3);
    s_clear_pulse();
    // 0 - (-65536) clamps positive.
    s_send(-65536, 1, 65535, 1, 1);
    tick(3);
    s_clear_pulse();
    // Adding negatives clamps negative.
    s_send(-65000, 0, -65000, 0, 1);
    s_send(-1000, 0, -65536, 1, 2);
    tick(3);

    // Narrow instance: random add/sub against an arithmetic model.
    m_acc = 0; m_ovf = 1'b0; m_cnt = 0;
    begin
      logic prev_valid;
      logic do_clear, vld, s;
      logic [9:0] d;
      int dv, sum;
      exp10_t e;
      prev_valid = 1'b0;
      for (int i = 0; i < 10000; i++) begin
        do_clear = !prev_valid && ($urandom_range(0, 399) == 0);
        vld      = ($urandom_range(0, 3) != 0);
        d        = 10'($urandom);
        s        = 1'($urandom_range(0, 1));
        n_clear = do_clear; n_in_valid = vld; n_in_data = d; n_sub = s;
        if (do_clear) begin
          m_acc = 0; m_ovf = 1'b0; m_cnt = 0;
        end else if (vld) begin
          dv  = int'($signed(d));
          sum = s ? (m_acc - dv) : (m_acc + dv);
          if (sum > 511) begin
            sum = sum - 1024; m_ovf = 1'b1;
          end else if (sum < -512) begin
            sum = sum + 1024; m_ovf = 1'b1;
          end
          m_acc = sum;
          if (m_cnt < 255) m_cnt++;
          e.acc = 10'(m_acc); e.ovf = m_ovf; e.cnt = 8'(m_cnt);
          n_q.push_back(e);
        end
        prev_valid = vld && !do_clear;
        tick(1);
      end
      n_clear = 1'b0; n_in_valid = 1'b0;
    end

    tick(4);
    check("w_queue_drained", 32'(w_q.size()), 32'd0);
    check("s_queue_drained", 32'(s_q.size()), 32'd0);
    check("n_queue_drained", 32'(n_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
